glyph_row_renderer: RTL and testbench
=====================================

# glyph_row_renderer

Streaming text renderer. Accepts ASCII character codes through a valid/ready handshake and buffers them in a small FIFO. Each character is expanded into a horizontally scaled pixel stream, one pixel per accepted transfer, with x/y coordinates attached. It sits between the game-logic text source and the frame-buffer writer, and replaces fixed per-letter combinational bitmap lookups with a parametrised, flow-controlled engine.

## Interface
- SCALE, 5: horizontal pixels per glyph column.
- GAP, 5: blank pixels between glyphs. No pixels are emitted for the gap; it only advances the x base.
- LINE_CHARS, 8: glyph slots per line before the cursor wraps.
- DEPTH, 4: character FIFO depth. Must be a power of two, 2 or more.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush. Empties the FIFO, aborts the glyph in progress and homes the cursor.
- char_valid  in  1  character offered.
- char_ready  out  1  FIFO can accept; equals !full.
- char_code  in  8  ASCII code.
- pix_valid  out  1  pixel output valid.
- pix_ready  in  1  downstream accepts the pixel.
- pix_on  out  1  pixel lit.
- pix_x  out  XW  absolute x. XW = $clog2(LINE_CHARS*(4*SCALE+GAP)).
- pix_y  out  3  glyph row, 0..5.
- pix_last  out  1  last pixel of the current glyph.
- busy  out  1  FIFO not empty, or state is not IDLE.

## Operation
- Glyphs are 4 columns by 6 rows. Row bit 3 is the leftmost column. Rows are listed top to bottom:
  - A: 6 9 9 F 9 9
  - D: E 9 9 9 9 E
  - E: F 8 E 8 8 F
  - G: 6 9 8 B 9 6
  - P: E 9 9 E 8 8
  - R: E 9 9 E 9 9
  - S: 6 9 4 2 9 6
  - T: F 2 2 2 2 2
  - U: 9 9 9 9 9 6
  - Every other code, including space (0x20), renders all-zero rows. A blank glyph still emits its full pixel stream.
- FIFO:
  - Push on char_valid && char_ready.
  - A push is refused while the FIFO is full, even in a cycle that pops.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop one entry and go to LOAD.
  - LOAD: register the glyph rows for the popped code, clear the row/col/sub counters, go to EMIT.
  - EMIT: present the pixel; on pix_ready, advance.
- Pixel counters:
  - Order is row-major: sub 0..SCALE-1 innermost, then col 0..3, then row 0..5.
  - Each glyph emits 24*SCALE pixels.
  - pix_x = base_x + col*SCALE + sub.
  - pix_on = row[3-col].
- End of glyph: on the accepted pixel with pix_last=1:
  - If slot == LINE_CHARS-1, set slot to 0 and base_x to 0.
  - Otherwise increment slot and add 4*SCALE+GAP to base_x.
  - Then go to IDLE.
- pix_x is zero-extended to XW; no overflow is possible within a line.
- clear takes priority over push and over pixel advance.
  - Next cycle: FIFO empty, state IDLE, slot 0, base_x 0, pix_valid 0.
  - A char offered in the same cycle as clear is dropped.

## Timing
- Reset values: char_ready 1, pix_valid 0, pix_on 0, pix_x 0, pix_y 0, pix_last 0, busy 0. FIFO empty, slot 0, state IDLE.
- Reset asserted mid-glyph returns everything to the reset values immediately, without waiting for a clock edge.
- Latency, char into an idle, empty block: accepted at edge N, pop in IDLE at N+1, LOAD at N+2, pix_valid high after edge N+2.
- Back-to-back glyphs: 2 idle cycles (IDLE, LOAD) between the last pixel of one glyph and the first pixel of the next.
- Backpressure: while pix_valid && !pix_ready, all pixel outputs hold stable.
- pix_valid never drops until the current pixel is accepted or clear/reset occurs.
- All outputs are registered.

## Configuration
- GLYPH_LOWERCASE_FOLD_EN:
  - Defined: codes 0x61..0x7A are mapped to 0x41..0x5A before lookup, so 'a' renders A.
  - Undefined: lowercase codes render blank.

## Structure
- Package glyph_pkg holds:
  - typedef glyph_t, an array of 6 rows of logic [3:0].
  - localparams for the 9 glyph bitmaps.
  - GLYPH_ROWS=6, GLYPH_COLS=4.
  - function glyph_lookup(code), returning glyph_t.
- Sub-module glyph_char_fifo (DEPTH, 8-bit data, full/empty flags); the renderer FSM lives in the top level.

## Test plan
- Reset: assert reset mid-stream -> all outputs at reset values; char_ready=1 after release.
- Single 'T' (0x54), SCALE=5, pix_ready=1 -> 120 pixels:
  - Row 0: x 0..19 all on.
  - Rows 1..5: only x 10..14 on.
  - pix_last on pixel 119.
  - First pix_valid 2 cycles after acceptance.
- Code 0x5A ('Z') -> 120 pixels, all pix_on=0, pix_last on pixel 119.
- FIFO full: pix_ready=0, offer 6 chars -> 1 popped plus 4 buffered accepted; char_ready=0 on the 6th; pixel outputs stable throughout the stall.
- Wrap: 9 chars 'A' -> glyph k starts at x=25k for k=0..7; glyph 8 starts at x=0.
- Lowercase 'g' (0x67) -> row 3 x 0..4 and 10..19 on with GLYPH_LOWERCASE_FOLD_EN defined; all off without it. Also clear mid-glyph -> pix_valid 0 next cycle, next char starts at x=0.

Source files
------------

// File: rtl/glyph_pkg.sv
// Shared types, glyph bitmaps and code lookup for glyph_row_renderer.
// Optional build macro: GLYPH_LOWERCASE_FOLD_EN folds 'a'..'z' onto 'A'..'Z'.
package glyph_pkg;

  localparam int GLYPH_ROWS = 6;
  localparam int GLYPH_COLS = 4;

  typedef logic [GLYPH_ROWS-1:0][GLYPH_COLS-1:0] glyph_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  // Literals list the bottom row first so that index 0 is the top row.
  localparam glyph_t GLYPH_A = {4'h9, 4'h9, 4'hF, 4'h9, 4'h9, 4'h6};
  localparam glyph_t GLYPH_D = {4'hE, 4'h9, 4'h9, 4'h9, 4'h9, 4'hE};
  localparam glyph_t GLYPH_E = {4'hF, 4'h8, 4'h8, 4'hE, 4'h8, 4'hF};
  localparam glyph_t GLYPH_G = {4'h6, 4'h9, 4'hB, 4'h8, 4'h9, 4'h6};
  localparam glyph_t GLYPH_P = {4'h8, 4'h8, 4'hE, 4'h9, 4'h9, 4'hE};
  localparam glyph_t GLYPH_R = {4'h9, 4'h9, 4'hE, 4'h9, 4'h9, 4'hE};
  localparam glyph_t GLYPH_S = {4'h6, 4'h9, 4'h2, 4'h4, 4'h9, 4'h6};
  localparam glyph_t GLYPH_T = {4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'hF};
  localparam glyph_t GLYPH_U = {4'h6, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9};

  function automatic glyph_t glyph_lookup(input logic [7:0] code);
    logic [7:0] c;
`ifdef GLYPH_LOWERCASE_FOLD_EN
    if (code >= 8'h61 && code <= 8'h7A) c = code - 8'h20;
    else c = code;
`else
    c = code;
`endif
    case (c)
      8'h41:   glyph_lookup = GLYPH_A;
      8'h44:   glyph_lookup = GLYPH_D;
      8'h45:   glyph_lookup = GLYPH_E;
      8'h47:   glyph_lookup = GLYPH_G;
      8'h50:   glyph_lookup = GLYPH_P;
      8'h52:   glyph_lookup = GLYPH_R;
      8'h53:   glyph_lookup = GLYPH_S;
      8'h54:   glyph_lookup = GLYPH_T;
      8'h55:   glyph_lookup = GLYPH_U;
      default: glyph_lookup = '0;
    endcase
  endfunction

endpackage

// File: rtl/glyph_char_fifo.sv
// Small character FIFO with full/empty flags and synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module glyph_char_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == (AW+1)'(0));
  assign pop_data = mem_q[rd_ptr_q];
  // A full FIFO refuses pushes even when it pops in the same cycle.
  assign do_push  = push && !full && !clear;
  assign do_pop   = pop && !empty && !clear;

  // Next-state pointers, occupancy and storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      count_d  = (AW+1)'(0);
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      else rd_ptr_d = rd_ptr_q;
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/glyph_row_renderer.sv
// Streaming glyph renderer: FIFO-buffered ASCII codes expanded into scaled pixels.
// Build macro GLYPH_LOWERCASE_FOLD_EN (see glyph_pkg) renders lowercase as uppercase.
module glyph_row_renderer
  import glyph_pkg::*;
#(
  parameter int SCALE      = 5,
  parameter int GAP        = 5,
  parameter int LINE_CHARS = 8,
  parameter int DEPTH      = 4,
  localparam int XW        = $clog2(LINE_CHARS*(4*SCALE+GAP))
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          char_valid,
  output logic          char_ready,
  input  logic [7:0]    char_code,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_on,
  output logic [XW-1:0] pix_x,
  output logic [2:0]    pix_y,
  output logic          pix_last,
  output logic          busy
);

  localparam int SW = $clog2(SCALE+1);
  localparam int LW = $clog2(LINE_CHARS+1);
  localparam logic [XW-1:0] PITCH = XW'(4*SCALE+GAP);

  state_t        state_q, state_d;
  logic [7:0]    code_q, code_d;
  glyph_t        glyph_q, glyph_d;
  logic [2:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [LW-1:0] slot_q, slot_d;
  logic [XW-1:0] base_x_q, base_x_d;
  logic          pix_valid_q, pix_valid_d;
  logic          pix_on_q, pix_on_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [2:0]    pix_y_q, pix_y_d;
  logic          pix_last_q, pix_last_d;
  logic          load_pixel;
  logic          fifo_pop;
  logic [7:0]    fifo_data;
  logic          fifo_full;
  logic          fifo_empty;

  glyph_char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (char_valid),
    .push_data (char_code),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign char_ready = !fifo_full;
  assign busy       = !fifo_empty || (state_q != S_IDLE);
  assign pix_valid  = pix_valid_q;
  assign pix_on     = pix_on_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_last   = pix_last_q;

  // Renderer FSM, pixel counters, cursor and next registered pixel.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    glyph_d     = glyph_q;
    row_d       = row_q;
    col_d       = col_q;
    sub_d       = sub_q;
    slot_d      = slot_q;
    base_x_d    = base_x_q;
    pix_valid_d = pix_valid_q;
    pix_on_d    = pix_on_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_last_d  = pix_last_q;
    load_pixel  = 1'b0;
    fifo_pop    = 1'b0;
    if (clear) begin
      state_d     = S_IDLE;
      slot_d      = LW'(0);
      base_x_d    = XW'(0);
      pix_valid_d = 1'b0;
      pix_last_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            code_d   = fifo_data;
            state_d  = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          glyph_d    = glyph_lookup(code_q);
          row_d      = 3'd0;
          col_d      = 2'd0;
          sub_d      = SW'(0);
          state_d    = S_EMIT;
          load_pixel = 1'b1;
        end
        S_EMIT: begin
          if (pix_ready) begin
            if (pix_last_q) begin
              if (slot_q == LW'(LINE_CHARS-1)) begin
                slot_d   = LW'(0);
                base_x_d = XW'(0);
              end else begin
                slot_d   = slot_q + LW'(1);
                base_x_d = base_x_q + PITCH;
              end
              state_d     = S_IDLE;
              pix_valid_d = 1'b0;
              pix_last_d  = 1'b0;
            end else begin
              // Row-major walk: sub innermost, then column, then row.
              if (sub_q == SW'(SCALE-1)) begin
                sub_d = SW'(0);
                if (col_q == 2'd3) begin
                  col_d = 2'd0;
                  row_d = row_q + 3'd1;
                end else begin
                  col_d = col_q + 2'd1;
                end
              end else begin
                sub_d = sub_q + SW'(1);
              end
              load_pixel = 1'b1;
            end
          end else begin
            state_d = S_EMIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (load_pixel) begin
        pix_valid_d = 1'b1;
        pix_on_d    = glyph_d[row_d][2'd3 - col_d];
        pix_x_d     = base_x_d + XW'(col_d) * XW'(SCALE) + XW'(sub_d);
        pix_y_d     = row_d;
        pix_last_d  = (row_d == 3'd5) && (col_d == 2'd3) && (sub_d == SW'(SCALE-1));
      end else begin
        pix_on_d = pix_on_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      code_q      <= 8'h00;
      glyph_q     <= '0;
      row_q       <= 3'd0;
      col_q       <= 2'd0;
      sub_q       <= SW'(0);
      slot_q      <= LW'(0);
      base_x_q    <= XW'(0);
      pix_valid_q <= 1'b0;
      pix_on_q    <= 1'b0;
      pix_x_q     <= XW'(0);
      pix_y_q     <= 3'd0;
      pix_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      glyph_q     <= glyph_d;
      row_q       <= row_d;
      col_q       <= col_d;
      sub_q       <= sub_d;
      slot_q      <= slot_d;
      base_x_q    <= base_x_d;
      pix_valid_q <= pix_valid_d;
      pix_on_q    <= pix_on_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_last_q  <= pix_last_d;
    end
  end

endmodule

// File: tb/tb_glyph_row_renderer.sv
// Scoreboard bench for glyph_row_renderer: a glyph-table model expands each accepted
// character into expected pixels; a negedge monitor pops and compares accepted pixels.
module tb_glyph_row_renderer;

  localparam int SCALE      = 5;
  localparam int GAP        = 5;
  localparam int LINE_CHARS = 8;
  localparam int DEPTH      = 4;
  localparam int XW         = $clog2(LINE_CHARS*(4*SCALE+GAP));

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          char_valid;
  logic          char_ready;
  logic [7:0]    char_code;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic          pix_on;
  logic [XW-1:0] pix_x;
  logic [2:0]    pix_y;
  logic          pix_last;
  logic          busy;

  always #5 clk = ~clk;

  glyph_row_renderer #(
    .SCALE(SCALE), .GAP(GAP), .LINE_CHARS(LINE_CHARS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .char_valid(char_valid), .char_ready(char_ready), .char_code(char_code),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_on(pix_on),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .busy(busy)
  );

  typedef struct {
    logic on;
    int   x;
    int   y;
    logic last;
  } px_t;

  px_t           exp_q[$];
  px_t           e;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            m_slot = 0;
  int            lit_count = 0;
  int            pix_seen = 0;
  int            ready_mode = 1;
  logic          hold_v = 1'b0;
  logic [XW+4:0] hold_val;
  logic [7:0]    letters [10] = '{8'h41, 8'h44, 8'h45, 8'h47, 8'h50,
                                  8'h52, 8'h53, 8'h54, 8'h55, 8'h20};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Glyph rows written top to bottom, one hex digit per row, leftmost pixel = bit 3.
  function automatic logic [23:0] glyph_rows(input logic [7:0] code_in);
    logic [7:0] c;
    c = code_in;
`ifdef GLYPH_LOWERCASE_FOLD_EN
    if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
`endif
    case (c)
      8'h41:   return 24'h699F99;
      8'h44:   return 24'hE9999E;
      8'h45:   return 24'hF8E88F;
      8'h47:   return 24'h698B96;
      8'h50:   return 24'hE99E88;
      8'h52:   return 24'hE99E99;
      8'h53:   return 24'h694296;
      8'h54:   return 24'hF22222;
      8'h55:   return 24'h999996;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_push(input logic [7:0] code);
    logic [23:0] g;
    logic [23:0] t;
    px_t p;
    g = glyph_rows(code);
    for (int r = 0; r < 6; r++) begin
      t = g >> (4 * (5 - r));
      for (int c = 0; c < 4; c++) begin
        for (int s = 0; s < SCALE; s++) begin
          p.on   = t[3 - c];
          p.x    = m_slot * (4*SCALE + GAP) + c * SCALE + s;
          p.y    = r;
          p.last = (r == 5 && c == 3 && s == SCALE - 1);
          exp_q.push_back(p);
        end
      end
    end
    m_slot = (m_slot + 1) % LINE_CHARS;
  endtask

  // Monitor, stability checker and model feed, all sampled mid-cycle.
  always @(negedge clk) begin
    if (reset || clear) begin
      exp_q.delete();
      m_slot = 0;
      hold_v = 1'b0;
    end else begin
      if (pix_valid) begin
        if (hold_v) check("hold_stable", {pix_on, pix_x, pix_y, pix_last}, hold_val);
        if (pix_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_pixel", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("pix_on", pix_on, e.on);
            check("pix_x", pix_x, e.x);
            check("pix_y", pix_y, e.y);
            check("pix_last", pix_last, e.last);
            if (pix_on) lit_count++;
            pix_seen++;
          end
          hold_v = 1'b0;
        end else begin
          hold_v   = 1'b1;
          hold_val = {pix_on, pix_x, pix_y, pix_last};
        end
      end else begin
        if (hold_v) check("valid_held", 0, 1);
        hold_v = 1'b0;
      end
      if (char_valid && char_ready) model_push(char_code);
    end
  end

  // Downstream ready: forced low, forced high, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send_char(input logic [7:0] code);
    int   k;
    logic r;
    k = 0;
    r = 1'b0;
    char_valid = 1'b1;
    char_code  = code;
    while (!r && k < 3000) begin
      @(negedge clk);
      r = char_ready;
      @(posedge clk);
      #1;
      k++;
    end
    char_valid = 1'b0;
    if (!r) check("accept_timeout", r, 1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 30000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_done", (k < 30000), 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    logic last_r;
    logic [7:0] code;
    reset = 1'b1; clear = 1'b0; char_valid = 1'b0; char_code = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_char_ready", char_ready, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_pix_on", pix_on, 0);
    check("rst_pix_last", pix_last, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 'T' with latency check
    lit_count = 0; pix_seen = 0;
    char_valid = 1'b1; char_code = 8'h54;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    check("lat_edge_n", pix_valid, 0);
    @(posedge clk);
    #1;
    check("lat_edge_n1", pix_valid, 0);
    @(posedge clk);
    #1;
    check("lat_edge_n2", pix_valid, 1);
    wait_drain();
    check("t_lit_count", lit_count, 45);
    check("t_pix_count", pix_seen, 24*SCALE);

    // Unknown code renders blank but full length
    lit_count = 0; pix_seen = 0;
    send_char(8'h5A);
    wait_drain();
    check("z_lit_count", lit_count, 0);
    check("z_pix_count", pix_seen, 24*SCALE);

    // FIFO full under stalled output
    ready_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    acc = 0; last_r = 1'b1;
    for (int i = 0; i < 6; i++) begin
      char_valid = 1'b1;
      char_code  = letters[$urandom_range(0, 9)];
      @(negedge clk);
      last_r = char_ready;
      if (last_r) acc++;
      @(posedge clk);
      #1;
    end
    char_valid = 1'b0;
    check("full_accepts", acc, 5);
    check("full_refused", last_r, 0);
    repeat (20) begin @(posedge clk); #1; end
    check("stall_valid", pix_valid, 1);
    ready_mode = 2;
    wait_drain();

    // Line wrap from a homed cursor
    pulse_clear();
    for (int i = 0; i < 9; i++) send_char(8'h41);
    wait_drain();

    // Lowercase
    send_char(8'h67);
    wait_drain();

    // Clear mid-glyph, char offered with clear is dropped
    ready_mode = 1;
    send_char(8'h41);
    repeat (30) begin @(posedge clk); #1; end
    clear = 1'b1; char_valid = 1'b1; char_code = 8'h45;
    @(posedge clk);
    #1;
    clear = 1'b0; char_valid = 1'b0;
    check("clr_pix_valid", pix_valid, 0);
    check("clr_busy", busy, 0);
    check("clr_char_ready", char_ready, 1);
    send_char(8'h54);
    wait_drain();

    // Random traffic
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    code = letters[$urandom_range(0, 9)];
        2:       code = letters[$urandom_range(0, 8)] | 8'h20;
        default: code = 8'($urandom_range(0, 255));
      endcase
      send_char(code);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) begin @(posedge clk); #1; end
      end
    end
    wait_drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) send_char(letters[$urandom_range(0, 8)]);
    repeat (40) begin @(posedge clk); #1; end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pix_valid", pix_valid, 0);
    check("arst_pix_on", pix_on, 0);
    check("arst_pix_x", pix_x, 0);
    check("arst_pix_y", pix_y, 0);
    check("arst_pix_last", pix_last, 0);
    check("arst_busy", busy, 0);
    check("arst_char_ready", char_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_rst_char_ready", char_ready, 1);
    send_char(8'h55);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
